// File: rtl/voq_sched.sv
// voq_sched: single-iteration iSLIP crossbar scheduler for a fixed-length VOQ switch.
// Per time slot: snapshot the VOQ empty flags, run one grant/accept round, then
// pulse the dequeue port of every matched ingress and drive the crossbar selects
// for the rest of the slot.
// Optional build macro: SCHED_STATS_EN adds the match_cnt / idle_slot_cnt counters.
module voq_sched #(
  parameter int PORT_CNT    = 4,
  parameter int SLOT_CYCLES = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic [PORT_CNT*PORT_CNT-1:0]         is_empty,
  output logic [PORT_CNT-1:0]                  sched_en,
  output logic [PORT_CNT*$clog2(PORT_CNT)-1:0] sched_sel,
  output logic [PORT_CNT-1:0]                  xbar_valid,
  output logic [PORT_CNT*$clog2(PORT_CNT)-1:0] xbar_sel,
  output logic                                 slot_start
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]                          match_cnt,
  output logic [31:0]                          idle_slot_cnt
`endif
);

  localparam int SEL_W = $clog2(PORT_CNT);
  localparam int CNT_W = $clog2(SLOT_CYCLES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT  = 3'd1,
    ACCEPT = 3'd2,
    ISSUE  = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t                                  state_q;
  logic [CNT_W-1:0]                        cnt_q;
  logic [PORT_CNT-1:0][PORT_CNT-1:0]       req_q;    // req_q[i][j]: ingress i wants egress j
  logic [PORT_CNT-1:0][PORT_CNT-1:0]       req_d;
  logic [PORT_CNT-1:0][SEL_W-1:0]          gptr_q;   // per egress
  logic [PORT_CNT-1:0][SEL_W-1:0]          aptr_q;   // per ingress
  logic [PORT_CNT-1:0]                     sched_en_q;
  logic [PORT_CNT-1:0][SEL_W-1:0]          sched_sel_q;
  logic [PORT_CNT-1:0]                     xbar_valid_q;
  logic [PORT_CNT-1:0][SEL_W-1:0]          xbar_sel_q;
  logic                                    slot_start_q;

  logic [PORT_CNT-1:0][PORT_CNT-1:0]       gnt_d;    // gnt_d[i][j]: egress j grants ingress i
  logic [PORT_CNT-1:0]                     col_d;
  logic [SEL_W:0]                          pick_d;
  logic [PORT_CNT-1:0]                     match_v_d;
  logic [PORT_CNT-1:0][SEL_W-1:0]          match_sel_d;
  logic [PORT_CNT-1:0][SEL_W-1:0]          sched_sel_d;
  logic [PORT_CNT-1:0]                     xbar_valid_d;
  logic [PORT_CNT-1:0][SEL_W-1:0]          xbar_sel_d;

  // Round-robin pick: first set bit of vec at or after ptr, with wrap.
  // Returns {found, index}.
  function automatic logic [SEL_W:0] rr_pick(input logic [PORT_CNT-1:0] vec,
                                             input logic [SEL_W-1:0]    ptr);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    res = '0;
    // Walk backwards so the candidate closest to ptr is the one left standing.
    for (int k = PORT_CNT - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (vec[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Reshape the flat empty flags into a request matrix.
  always_comb begin
    req_d = '0;
    for (int i = 0; i < PORT_CNT; i++) begin
      for (int j = 0; j < PORT_CNT; j++) begin
        req_d[i][j] = ~is_empty[i*PORT_CNT + j];
      end
    end
  end

  // One iSLIP iteration on the snapshot: egress grant, then ingress accept.
  always_comb begin
    gnt_d        = '0;
    col_d        = '0;
    pick_d       = '0;
    match_v_d    = '0;
    match_sel_d  = '0;
    sched_sel_d  = '0;
    xbar_valid_d = '0;
    xbar_sel_d   = '0;
    for (int j = 0; j < PORT_CNT; j++) begin
      for (int i = 0; i < PORT_CNT; i++) begin
        col_d[i] = req_q[i][j];
      end
      pick_d = rr_pick(col_d, gptr_q[j]);
      if (pick_d[SEL_W]) begin
        gnt_d[pick_d[SEL_W-1:0]][j] = 1'b1;
      end else begin
        gnt_d = gnt_d;
      end
    end
    for (int i = 0; i < PORT_CNT; i++) begin
      pick_d         = rr_pick(gnt_d[i], aptr_q[i]);
      match_v_d[i]   = pick_d[SEL_W];
      match_sel_d[i] = pick_d[SEL_W-1:0];
      if (pick_d[SEL_W]) begin
        sched_sel_d[i]                   = pick_d[SEL_W-1:0];
        xbar_valid_d[pick_d[SEL_W-1:0]]  = 1'b1;
        xbar_sel_d[pick_d[SEL_W-1:0]]    = SEL_W'(i);
      end else begin
        sched_sel_d[i] = '0;
      end
    end
  end

  // Slot FSM with registered outputs and iSLIP pointer updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      gptr_q       <= '0;
      aptr_q       <= '0;
      sched_en_q   <= '0;
      sched_sel_q  <= '0;
      xbar_valid_q <= '0;
      xbar_sel_q   <= '0;
      slot_start_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q      <= GRANT;
            slot_start_q <= 1'b1;
          end
        end
        GRANT: begin
          // Snapshot is frozen here; later empty-flag changes wait for the next slot.
          slot_start_q <= 1'b0;
          req_q        <= req_d;
          state_q      <= ACCEPT;
        end
        ACCEPT: begin
          sched_en_q   <= match_v_d;
          sched_sel_q  <= sched_sel_d;
          xbar_valid_q <= xbar_valid_d;
          xbar_sel_q   <= xbar_sel_d;
          // Only accepted matches advance pointers (keeps iSLIP starvation-free).
          for (int i = 0; i < PORT_CNT; i++) begin
            if (match_v_d[i]) begin
              aptr_q[i]              <= match_sel_d[i] + SEL_W'(1);
              gptr_q[match_sel_d[i]] <= SEL_W'(i + 1);
            end
          end
          state_q <= ISSUE;
        end
        ISSUE: begin
          sched_en_q  <= '0;
          sched_sel_q <= '0;
          cnt_q       <= CNT_W'(SLOT_CYCLES - 4);
          state_q     <= HOLD;
        end
        HOLD: begin
          if (cnt_q == '0) begin
            xbar_valid_q <= '0;
            xbar_sel_q   <= '0;
            if (enable) begin
              state_q      <= GRANT;
              slot_start_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sched_en   = sched_en_q;
  assign sched_sel  = sched_sel_q;
  assign xbar_valid = xbar_valid_q;
  assign xbar_sel   = xbar_sel_q;
  assign slot_start = slot_start_q;

`ifdef SCHED_STATS_EN
  logic [31:0] match_cnt_q;
  logic [31:0] idle_slot_cnt_q;

  function automatic logic [31:0] popcount(input logic [PORT_CNT-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int k = 0; k < PORT_CNT; k++) begin
      n = n + {31'd0, v[k]};
    end
    return n;
  endfunction

  // Accumulate match statistics once per ISSUE cycle; counters wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      match_cnt_q     <= '0;
      idle_slot_cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      match_cnt_q <= match_cnt_q + popcount(sched_en_q);
      if (sched_en_q == '0) begin
        idle_slot_cnt_q <= idle_slot_cnt_q + 32'd1;
      end
    end
  end

  assign match_cnt     = match_cnt_q;
  assign idle_slot_cnt = idle_slot_cnt_q;
`endif

endmodule

// File: tb/tb_voq_sched.sv
// Directed self-checking bench for voq_sched (PORT_CNT=4, SLOT_CYCLES=8).
// Outputs are sampled on the falling edge; the slot is located via slot_start
// (GRANT), so ISSUE is two falling edges later.
module tb_voq_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] is_empty;
  logic [3:0]  sched_en;
  logic [7:0]  sched_sel;
  logic [3:0]  xbar_valid;
  logic [7:0]  xbar_sel;
  logic        slot_start;
`ifdef SCHED_STATS_EN
  logic [31:0] match_cnt;
  logic [31:0] idle_slot_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [24:0] all_out;
  assign all_out = {sched_en, sched_sel, xbar_valid, xbar_sel, slot_start};

  // Hand-computed tables.
  logic [3:0] t3_en  [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
  logic [7:0] t3_xs  [4] = '{8'h00, 8'h01, 8'h02, 8'h03};
  logic [3:0] t4_en  [4] = '{4'h1, 4'h3, 4'h7, 4'hF};
  logic [7:0] t4_sel [4] = '{8'h00, 8'h01, 8'h06, 8'h1B};
  logic [7:0] t4_xs  [4] = '{8'h00, 8'h01, 8'h06, 8'h1B};

  voq_sched #(.PORT_CNT(4), .SLOT_CYCLES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .is_empty   (is_empty),
    .sched_en   (sched_en),
    .sched_sel  (sched_sel),
    .xbar_valid (xbar_valid),
    .xbar_sel   (xbar_sel),
    .slot_start (slot_start)
`ifdef SCHED_STATS_EN
    ,
    .match_cnt     (match_cnt),
    .idle_slot_cnt (idle_slot_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  // Advance to the falling edge inside the next GRANT cycle, bounded.
  task automatic wait_grant(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (slot_start) seen = 1'b1;
    end
    check_eq(tag, {63'd0, seen}, 64'd1);
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    is_empty = 16'h0000;
    step(2);
    reset = 1'b0;

    // 1: disabled, requests present -> everything stays 0
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_eq("t1_idle_outputs", {39'd0, all_out}, 64'd0);
    end

    // 2: single request ingress 2 -> egress 1
    do_reset();
    is_empty = 16'hFDFF;
    enable   = 1'b1;
    wait_grant("t2_grant_seen");
    check_eq("t2_grant_xbar_off", {60'd0, xbar_valid}, 64'd0);
    check_eq("t2_grant_no_pulse", {60'd0, sched_en}, 64'd0);
    step(1);
    check_eq("t2_accept_slot_start_low", {63'd0, slot_start}, 64'd0);
    step(1);
    check_eq("t2_issue_en", {60'd0, sched_en}, 64'h4);
    check_eq("t2_issue_sel2", {62'd0, sched_sel[5:4]}, 64'd1);
    check_eq("t2_issue_xv", {60'd0, xbar_valid}, 64'h2);
    check_eq("t2_issue_xs1", {62'd0, xbar_sel[3:2]}, 64'd2);
    for (int c = 0; c < 5; c++) begin
      step(1);
      check_eq("t2_hold_xv", {60'd0, xbar_valid}, 64'h2);
      check_eq("t2_hold_no_pulse", {60'd0, sched_en}, 64'd0);
    end
    step(1);
    check_eq("t2_period_slot_start", {63'd0, slot_start}, 64'd1);
    check_eq("t2_next_grant_xv_clear", {60'd0, xbar_valid}, 64'd0);
    enable = 1'b0;

    // 3: everyone wants egress 0 -> winner rotates
    do_reset();
    is_empty = 16'hEEEE;
    enable   = 1'b1;
    for (int s = 0; s < 4; s++) begin
      wait_grant("t3_grant_seen");
      step(2);
      check_eq("t3_issue_en", {60'd0, sched_en}, {60'd0, t3_en[s]});
      check_eq("t3_issue_sel", {56'd0, sched_sel}, 64'd0);
      check_eq("t3_issue_xv", {60'd0, xbar_valid}, 64'h1);
      check_eq("t3_issue_xs", {56'd0, xbar_sel}, {56'd0, t3_xs[s]});
    end

    // 4: all VOQs full from reset -> pointers desynchronise
    do_reset();
    is_empty = 16'h0000;
    enable   = 1'b1;
    for (int s = 0; s < 4; s++) begin
      wait_grant("t4_grant_seen");
      step(2);
      check_eq("t4_issue_en", {60'd0, sched_en}, {60'd0, t4_en[s]});
      check_eq("t4_issue_sel", {56'd0, sched_sel}, {56'd0, t4_sel[s]});
      check_eq("t4_issue_xv", {60'd0, xbar_valid}, {60'd0, t4_en[s]});
      check_eq("t4_issue_xs", {56'd0, xbar_sel}, {56'd0, t4_xs[s]});
    end
    // all-empty slot; flags refill after the snapshot and must be ignored
    is_empty = 16'hFFFF;
    wait_grant("t4e_grant_seen");
    step(1);
    is_empty = 16'h0000;
    step(1);
    check_eq("t4e_issue_en", {60'd0, sched_en}, 64'd0);
    check_eq("t4e_issue_xv", {60'd0, xbar_valid}, 64'd0);
    step(1);
`ifdef SCHED_STATS_EN
    check_eq("t6_match_cnt", {32'd0, match_cnt}, 64'd10);
    check_eq("t6_idle_slot_cnt", {32'd0, idle_slot_cnt}, 64'd1);
`endif
    enable = 1'b0;

    // 5a: enable dropped in HOLD -> slot completes, then IDLE
    do_reset();
    is_empty = 16'h0000;
    enable   = 1'b1;
    wait_grant("t5_grant_seen");
    step(3);
    enable = 1'b0;
    step(4);
    check_eq("t5_last_hold_xv", {60'd0, xbar_valid}, 64'h1);
    step(1);
    check_eq("t5_idle_slot_start", {63'd0, slot_start}, 64'd0);
    check_eq("t5_idle_xv", {60'd0, xbar_valid}, 64'd0);
    for (int c = 0; c < 20; c++) begin
      step(1);
      check_eq("t5_idle_quiet", {55'd0, sched_en, xbar_valid, slot_start}, 64'd0);
    end

    // 5b: reset asserted in HOLD -> all outputs 0 next edge
    enable = 1'b1;
    wait_grant("t5b_grant_seen");
    step(4);
    check_eq("t5b_hold_active", {63'd0, (xbar_valid != 4'd0)}, 64'd1);
    reset = 1'b1;
    step(1);
    check_eq("t5b_reset_outputs", {39'd0, all_out}, 64'd0);
`ifdef SCHED_STATS_EN
    check_eq("t5b_reset_match_cnt", {32'd0, match_cnt}, 64'd0);
`endif
    reset  = 1'b0;
    enable = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
